quad_step_cmd_gen: RTL and testbench

- Upstream command stage for the 4-bit up/down counter FSM.
- Converts asynchronous quadrature encoder pins (A/B) and a clear button into the counter's 2-bit up_down command, one command per clock.
- Pipeline per channel: synchronise, glitch-filter, then phase-decode to produce forward steps, reverse steps, clear requests and illegal-transition errors.

---
 rtl/qstep_pkg.sv | 44 ++++
 rtl/quad_step_cmd_gen_filter.sv | 48 ++++
 rtl/quad_step_cmd_gen.sv | 107 ++++++++++
 tb/tb_quad_step_cmd_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/qstep_pkg.sv
// Shared types and defaults for the quadrature step command generator and the
// downstream up/down counter.
package qstep_pkg;

    typedef enum logic [1:0] {
        CMD_CLR  = 2'b00,
        CMD_UP   = 2'b01,
        CMD_DOWN = 2'b10,
        CMD_HOLD = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        INIT,
        P0,
        P1,
        P2,
        P3
    } phase_e;

    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_FILTER_CYCLES = 4;
    localparam int unsigned DEF_ERR_W         = 4;

    // Gray-order phase for a filtered AB pair (A is the MSB).
    function automatic phase_e phase_of(input logic a, input logic b);
        case ({a, b})
            2'b00:   return P0;
            2'b01:   return P1;
            2'b11:   return P2;
            default: return P3;
        endcase
    endfunction

    // Position of a phase around the quadrature cycle; INIT is never compared.
    function automatic logic [1:0] phase_idx(input phase_e ph);
        case (ph)
            P1:      return 2'd1;
            P2:      return 2'd2;
            P3:      return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/quad_step_cmd_gen_filter.sv
// One-bit synchroniser followed by a persistence filter: a new synced level is
// accepted only after it has differed from the filtered level for FILTER_CYCLES cycles.
module sync_glitch_filter
    import qstep_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level
);

    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // The edge that would bring the count to FILTER_CYCLES toggles the level instead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= 1'b0;
            cnt_q <= '0;
        end else if (synced != level) begin
            if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
                level <= synced;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/quad_step_cmd_gen.sv
// Quadrature encoder and clear button to a one-command-per-cycle up/down
// command stream for the 4-bit counter, with illegal-transition reporting.
module quad_step_cmd_gen
    import qstep_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int unsigned ERR_W         = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clr_in,
    output logic [1:0]       up_down,
    output logic             step,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic             ready
);

    localparam int unsigned INIT_CYCLES = SYNC_STAGES + FILTER_CYCLES + 1;
    localparam int unsigned SET_W       = $clog2(INIT_CYCLES + 1);

    logic a_f, b_f, clr_f, clr_q;

    sync_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
        .clk(clk), .reset(reset), .din(a_in), .level(a_f)
    );
    sync_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
        .clk(clk), .reset(reset), .din(b_in), .level(b_f)
    );
    sync_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_filt_clr (
        .clk(clk), .reset(reset), .din(clr_in), .level(clr_f)
    );

    phase_e           state_q, state_d, new_ph;
    cmd_e             cmd_q, cmd_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [ERR_W-1:0] err_count_d;
    logic             step_d, err_d, ready_d, clr_edge;
    logic [1:0]       delta;

    assign new_ph   = phase_of(a_f, b_f);
    assign clr_edge = clr_f & ~clr_q;
    assign delta    = phase_idx(new_ph) - phase_idx(state_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= INIT;
            settle_q  <= '0;
            clr_q     <= 1'b0;
            cmd_q     <= CMD_HOLD;
            step      <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
            ready     <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            clr_q     <= clr_f;
            cmd_q     <= cmd_d;
            step      <= step_d;
            err       <= err_d;
            err_count <= err_count_d;
            ready     <= ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        cmd_d       = CMD_HOLD;
        err_d       = 1'b0;
        err_count_d = err_count;
        ready_d     = ready;
        if (state_q == INIT) begin
            // clr edges seen while settling are dropped; clr_q still tracks the level.
            if (settle_q == SET_W'(INIT_CYCLES - 1)) begin
                state_d = new_ph;
                ready_d = 1'b1;
            end else begin
                settle_d = settle_q + 1'b1;
            end
        end else begin
            state_d = new_ph;
            case (delta)
                2'd1: cmd_d = CMD_UP;
                2'd3: cmd_d = CMD_DOWN;
                2'd2: begin
                    err_d = 1'b1;
                    if (err_count != '1) begin
                        err_count_d = err_count + 1'b1;
                    end
                end
                default: ;
            endcase
            if (clr_edge) begin
                cmd_d = CMD_CLR;
            end
        end
        step_d = (cmd_d == CMD_UP) || (cmd_d == CMD_DOWN);
    end

    assign up_down = cmd_q;

endmodule

// File: tb/tb_quad_step_cmd_gen.sv
// Scoreboard bench for quad_step_cmd_gen: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the DUT reports a command or error.
module tb_quad_step_cmd_gen;

    localparam int LAT = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       a_in = 1'b0, b_in = 1'b0, clr_in = 1'b0;
    logic [1:0] up_down;
    logic       step, err, ready;
    logic [3:0] err_count;

    typedef struct {
        logic [1:0] cmd;
        logic       err;
        int         cnt;
        int         cyc;
    } ev_t;

    ev_t        exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         exp_errs = 0;
    logic [3:0] cnt4 = '0;

    quad_step_cmd_gen #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .ERR_W(4)) dut (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .clr_in(clr_in),
        .up_down(up_down), .step(step), .err(err), .err_count(err_count), .ready(ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            total++;
            if (step !== (up_down == 2'b01 || up_down == 2'b10)) begin
                bad++;
                $display("FAIL step_flag cyc=%0d: step=%b up_down=%b", cyc, step, up_down);
            end
            if (up_down !== 2'b11 || err !== 1'b0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event cyc=%0d: up_down=%b err=%b, none expected",
                             cyc, up_down, err);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (up_down !== e.cmd || err !== e.err || err_count !== 4'(e.cnt) || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL event: got up_down=%b err=%b err_count=%0d cyc=%0d, want up_down=%b err=%b err_count=%0d cyc=%0d",
                                 up_down, err, err_count, cyc, e.cmd, e.err, e.cnt, e.cyc);
                    end
                end
                case (up_down)
                    2'b00: cnt4 = 4'd0;
                    2'b01: cnt4 = cnt4 + 4'd1;
                    2'b10: cnt4 = cnt4 - 4'd1;
                    default: ;
                endcase
            end
        end
    end

    task automatic drive(input logic a, input logic b, input logic c);
        @(posedge clk);
        #1;
        a_in = a;
        b_in = b;
        clr_in = c;
    endtask

    task automatic expect_ev(input logic [1:0] cmd, input logic e);
        ev_t ev;
        ev.cmd = cmd;
        ev.err = e;
        ev.cnt = exp_errs;
        ev.cyc = cyc + LAT;
        exp_q.push_back(ev);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_up_down"}, int'(up_down), 3);
        check({name, "_step"}, int'(step), 0);
        check({name, "_err"}, int'(err), 0);
        check({name, "_err_count"}, int'(err_count), 0);
        check({name, "_ready"}, int'(ready), 0);
    endtask

    initial begin
        #23;
        check_reset_vals("por");
        #4 reset = 1'b1;

        // ready rises on the 7th edge after reset release
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("ready_c%0d", i), int'(ready), (i >= 7) ? 1 : 0);
            check($sformatf("init_ud_c%0d", i), int'(up_down), 3);
        end

        // forward cycle 00->01->11->10->00
        cnt4 = '0;
        drive(0, 1, 0); expect_ev(2'b01, 0); idle(9);
        drive(1, 1, 0); expect_ev(2'b01, 0); idle(9);
        drive(1, 0, 0); expect_ev(2'b01, 0); idle(9);
        drive(0, 0, 0); expect_ev(2'b01, 0); idle(9);
        drain("fwd_drain");
        check("fwd_count", int'(cnt4), 4);

        // reverse cycle 00->10->11->01->00 from a cleared counter wraps to 12
        cnt4 = '0;
        drive(1, 0, 0); expect_ev(2'b10, 0); idle(9);
        drive(1, 1, 0); expect_ev(2'b10, 0); idle(9);
        drive(0, 1, 0); expect_ev(2'b10, 0); idle(9);
        drive(0, 0, 0); expect_ev(2'b10, 0); idle(9);
        drain("rev_drain");
        check("rev_count", int'(cnt4), 12);

        // 3-cycle glitch on A is filtered out
        drive(1, 0, 0); idle(2);
        drive(0, 0, 0); idle(12);
        drain("glitch3_drain");

        // 5-cycle pulse on B is accepted: P0->P1 then back
        drive(0, 1, 0); expect_ev(2'b01, 0); idle(4);
        drive(0, 0, 0); expect_ev(2'b10, 0); idle(12);
        drain("glitch5_drain");

        // 20 illegal double-bit transitions, saturating at 15
        for (int i = 0; i < 20; i++) begin
            if (exp_errs < 15) exp_errs++;
            drive(i[0] ? 1'b0 : 1'b1, i[0] ? 1'b0 : 1'b1, 0);
            expect_ev(2'b11, 1);
            idle(9);
        end
        drain("err_drain");
        check("err_sat", int'(err_count), 15);

        // clear with a same-cycle forward step: one clear, step dropped, phase advanced
        drive(0, 1, 1); expect_ev(2'b00, 0); idle(29);
        drive(0, 1, 0); idle(9);
        drive(1, 1, 0); expect_ev(2'b01, 0); idle(9);
        drain("clr_drain");
        check("clr_count", int'(cnt4), 1);

        // reset mid-filter discards the pending transition
        drive(1, 0, 0); idle(3);
        #2 reset = 1'b0;
        #1 check_reset_vals("mid_reset");
        idle(2);
        #3 reset = 1'b1;
        idle(15);
        check("post_reset_ready", int'(ready), 1);
        check("post_reset_err_count", int'(err_count), 0);
        drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
